// File: rtl/bus_pkg.sv
// Shared bus definitions: active-low strobe levels, word width, response-mux FSM states
// and the default watchdog timeout.
package bus_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int unsigned WORD_DATA_W     = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } bus_state_e;

endpackage

// File: rtl/bus_slave_prio_enc.sv
// Chip-select priority encoder: lowest asserted (active-low) cs_ index wins; also flags
// any and multiple assertions.
module bus_slave_prio_enc
  import bus_pkg::*;
#(
  parameter int unsigned SLAVE_NUM = 8,
  parameter int unsigned SEL_W     = 3
) (
  input  logic [SLAVE_NUM-1:0] cs_,
  output logic [SEL_W-1:0]     sel,
  output logic                 any_cs,
  output logic                 multi_cs
);

  logic [SLAVE_NUM-1:0] act;

  assign act      = ~cs_;
  assign any_cs   = |act;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_cs = |(act & (act - SLAVE_NUM'(1)));

  always_comb begin
    sel = '0;
    for (int i = int'(SLAVE_NUM) - 1; i >= 0; i--) begin
      if (cs_[i] == ENABLE_) begin
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_slave_resp_mux.sv
// Slave-response multiplexer: registers the selected slave's data/ready toward the master
// and aborts accesses whose slave never becomes ready with a one-cycle error response.
module bus_slave_resp_mux
  import bus_pkg::*;
#(
  parameter int unsigned SLAVE_NUM = 8,
  parameter int unsigned DATA_W    = WORD_DATA_W,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W     = 9,
  parameter int unsigned SEL_W     = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SLAVE_NUM-1:0]        s_cs_,
  input  logic [SLAVE_NUM-1:0]        s_rdy_,
  input  logic [SLAVE_NUM*DATA_W-1:0] s_rd_data,
  output logic [DATA_W-1:0]           m_rd_data,
  output logic                        m_rdy_,
  output logic                        m_err,
  output logic [SEL_W-1:0]            m_err_sel,
  output logic                        m_conflict
);

  logic [SEL_W-1:0]  sel;
  logic              any_cs;
  logic              multi_cs;

  logic [DATA_W-1:0] sel_data;
  logic              sel_rdy_;

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [SEL_W-1:0]  err_sel_q, err_sel_d;
  logic              conflict_q, conflict_d;

  bus_slave_prio_enc #(
    .SLAVE_NUM (SLAVE_NUM),
    .SEL_W     (SEL_W)
  ) u_prio_enc (
    .cs_      (s_cs_),
    .sel      (sel),
    .any_cs   (any_cs),
    .multi_cs (multi_cs)
  );

  // Index beyond the populated slaves falls through to 0 / DISABLE_.
  always_comb begin
    sel_data = '0;
    sel_rdy_ = DISABLE_;
    for (int i = 0; i < int'(SLAVE_NUM); i++) begin
      if (SEL_W'(i) == sel) begin
        sel_data = s_rd_data[i*DATA_W +: DATA_W];
        sel_rdy_ = s_rdy_[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    rd_data_d  = '0;
    rdy_d      = DISABLE_;
    err_d      = 1'b0;
    err_sel_d  = '0;
    conflict_d = multi_cs;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_cs) begin
          state_d = WAIT;
          sel_d   = sel;
          if (sel_rdy_ == ENABLE_) begin
            rd_data_d = sel_data;
            rdy_d     = ENABLE_;
          end
        end
      end

      WAIT: begin
        if (!any_cs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sel != sel_q) begin
          // Retarget restarts the watchdog for the new slave.
          cnt_d = '0;
          sel_d = sel;
          if (sel_rdy_ == ENABLE_) begin
            rd_data_d = sel_data;
            rdy_d     = ENABLE_;
          end
        end else if (sel_rdy_ == ENABLE_) begin
          rd_data_d = sel_data;
          rdy_d     = ENABLE_;
          cnt_d     = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdy_d     = ENABLE_;
          err_d     = 1'b1;
          err_sel_d = sel;
          cnt_d     = '0;
          state_d   = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DRAIN: begin
        cnt_d = '0;
        if (!any_cs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      rd_data_q  <= '0;
      rdy_q      <= DISABLE_;
      err_q      <= 1'b0;
      err_sel_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      rd_data_q  <= rd_data_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      err_sel_q  <= err_sel_d;
      conflict_q <= conflict_d;
    end
  end

  assign m_rd_data  = rd_data_q;
  assign m_rdy_     = rdy_q;
  assign m_err      = err_q;
  assign m_err_sel  = err_sel_q;
  assign m_conflict = conflict_q;

  // An error is always delivered as a completed (ready) cycle with zero data.
  a_err_is_resp: assert property (@(posedge clk) disable iff (reset)
    m_err |-> (m_rdy_ == ENABLE_ && m_rd_data == '0));

  a_cnt_bounded: assert property (@(posedge clk) disable iff (reset)
    cnt_q < CNT_W'(TIMEOUT));

endmodule

// File: tb/tb_bus_slave_resp_mux.sv
// Self-checking bench for bus_slave_resp_mux: per-cycle behavioural model plus directed
// literal checks of reset, read, priority/conflict, timeout, race and mid-access reset.
module tb_bus_slave_resp_mux;

  localparam int unsigned NS   = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 3;
  localparam int unsigned SW   = 3;

  logic                 clk;
  logic                 reset;
  logic [NS-1:0]        s_cs_;
  logic [NS-1:0]        s_rdy_;
  logic [NS*DW-1:0]     s_rd_data;
  logic [DW-1:0]        m_rd_data;
  logic                 m_rdy_;
  logic                 m_err;
  logic [SW-1:0]        m_err_sel;
  logic                 m_conflict;

  int checks   = 0;
  int failures = 0;

  bus_slave_resp_mux #(
    .SLAVE_NUM (NS),
    .DATA_W    (DW),
    .TIMEOUT   (TO),
    .CNT_W     (CW),
    .SEL_W     (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_cs_      (s_cs_),
    .s_rdy_     (s_rdy_),
    .s_rd_data  (s_rd_data),
    .m_rd_data  (m_rd_data),
    .m_rdy_     (m_rdy_),
    .m_err      (m_err),
    .m_err_sel  (m_err_sel),
    .m_conflict (m_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: an access is a run of cycles with some cs_ asserted; a "stall streak"
  // counts not-ready cycles that continue the same target; the TIMEOUT-th one aborts.
  logic [NS-1:0]    cs_v, rdy_v;
  logic [NS*DW-1:0] dat_v;
  logic             rst_v;
  bit               m_busy, m_aborted;
  int               m_tgt, m_streak;
  logic [DW-1:0]    e_data;
  logic             e_rdy, e_err, e_conf;
  logic [SW-1:0]    e_sel;

  initial begin : model_cmp
    forever begin
      int low;
      int ncs;
      @(posedge clk);
      cs_v  = s_cs_;
      rdy_v = s_rdy_;
      dat_v = s_rd_data;
      rst_v = reset;
      #1;
      e_data = '0; e_rdy = 1'b1; e_err = 1'b0; e_sel = '0; e_conf = 1'b0;
      if (rst_v) begin
        m_busy = 0; m_aborted = 0; m_tgt = 0; m_streak = 0;
      end else begin
        low = -1; ncs = 0;
        for (int i = 0; i < int'(NS); i++) begin
          if (!cs_v[i]) begin
            ncs++;
            if (low < 0) low = i;
          end
        end
        e_conf = (ncs > 1);
        if (low < 0) begin
          m_busy = 0; m_aborted = 0; m_streak = 0;
        end else if (!m_aborted) begin
          if (!rdy_v[low]) begin
            e_data   = dat_v[low*DW +: DW];
            e_rdy    = 1'b0;
            m_streak = 0;
          end else if (m_busy && low == m_tgt) begin
            m_streak++;
            if (m_streak == int'(TO)) begin
              e_rdy = 1'b0; e_err = 1'b1; e_sel = SW'(low);
              m_aborted = 1; m_streak = 0;
            end
          end else begin
            m_streak = 0;
          end
          m_busy = 1;
          m_tgt  = low;
        end
      end
      checks++;
      if (m_rdy_ !== e_rdy || m_err !== e_err || m_conflict !== e_conf ||
          m_rd_data !== e_data || (e_err && m_err_sel !== e_sel)) begin
        failures++;
        $display("FAIL model t=%0t got rdy_=%b err=%b sel=%0d conf=%b data=%h want rdy_=%b err=%b sel=%0d conf=%b data=%h",
                 $time, m_rdy_, m_err, m_err_sel, m_conflict, m_rd_data,
                 e_rdy, e_err, e_sel, e_conf, e_data);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NS-1:0] cs, input logic [NS-1:0] rdy);
    @(negedge clk);
    s_cs_  = cs;
    s_rdy_ = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] d);
    s_rd_data[idx*DW +: DW] = d;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset     = 1'b0;
    s_cs_     = '1;
    s_rdy_    = '1;
    s_rd_data = '0;
    for (int i = 0; i < int'(NS); i++) set_data(i, 32'hCAFE_0000 | DW'(i));

    // Reset: asynchronous assertion before any clock edge, then held 3 cycles.
    #1 reset = 1'b1;
    #1;
    chk("rst_async_rdy", 64'(m_rdy_), 64'h1);
    chk("rst_async_data", 64'(m_rd_data), 64'h0);
    chk("rst_async_err", 64'(m_err), 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_hold_rdy", 64'(m_rdy_), 64'h1);
      chk("rst_hold_err", 64'(m_err), 64'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("idle_rdy", 64'(m_rdy_), 64'h1);

    // Normal read from slave 5.
    drive(8'b1101_1111, 8'b1101_1111);
    set_data(5, 32'hCAFE_0005);
    tick();
    chk("read5_rdy", 64'(m_rdy_), 64'h0);
    chk("read5_data", 64'(m_rd_data), 64'hCAFE_0005);
    chk("read5_err", 64'(m_err), 64'h0);
    drive('1, '1);
    tick();
    chk("read5_release_rdy", 64'(m_rdy_), 64'h1);

    // Priority and conflict: slaves 2 and 6 both selected and ready.
    set_data(2, 32'h22);
    set_data(6, 32'h66);
    drive(8'b1011_1011, 8'b1011_1011);
    tick();
    chk("prio_data", 64'(m_rd_data), 64'h22);
    chk("prio_conflict", 64'(m_conflict), 64'h1);
    drive('1, '1);
    tick();
    chk("prio_conflict_clear", 64'(m_conflict), 64'h0);

    // Timeout on slave 3; late ready afterwards is suppressed.
    set_data(3, 32'hDEAD_0003);
    drive(8'b1111_0111, '1);
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("to_wait_err", 64'(m_err), 64'h0);
      chk("to_wait_rdy", 64'(m_rdy_), 64'h1);
      tick();
    end
    chk("to_err", 64'(m_err), 64'h1);
    chk("to_err_sel", 64'(m_err_sel), 64'h3);
    chk("to_err_rdy", 64'(m_rdy_), 64'h0);
    chk("to_err_data", 64'(m_rd_data), 64'h0);
    drive(8'b1111_0111, 8'b1111_0111);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("drain_rdy", 64'(m_rdy_), 64'h1);
      chk("drain_err", 64'(m_err), 64'h0);
    end
    drive('1, '1);
    tick();

    // Race: ready arrives on the cycle the watchdog would fire; access stays live after.
    set_data(1, 32'h1111_0001);
    drive(8'b1111_1101, '1);
    tick();
    for (int c = 0; c < 3; c++) tick();
    chk("race_pre_err", 64'(m_err), 64'h0);
    drive(8'b1111_1101, 8'b1111_1101);
    tick();
    chk("race_rdy", 64'(m_rdy_), 64'h0);
    chk("race_err", 64'(m_err), 64'h0);
    chk("race_data", 64'(m_rd_data), 64'h1111_0001);
    drive(8'b1111_1101, '1);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("race_rewait_err", 64'(m_err), 64'h0);
      tick();
    end
    chk("race_second_to_err", 64'(m_err), 64'h1);
    chk("race_second_to_sel", 64'(m_err_sel), 64'h1);
    drive('1, '1);
    tick();

    // Reset mid-access (slaves 4 and 7 selected, count at 2), then full restart.
    drive(8'b0110_1111, '1);
    tick();
    tick();
    tick();
    chk("pre_rst_conflict", 64'(m_conflict), 64'h1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_conflict", 64'(m_conflict), 64'h0);
    chk("mid_rst_rdy", 64'(m_rdy_), 64'h1);
    chk("mid_rst_err", 64'(m_err), 64'h0);
    chk("mid_rst_data", 64'(m_rd_data), 64'h0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("rst_restart_err", 64'(m_err), 64'h0);
      tick();
    end
    chk("rst_restart_to_err", 64'(m_err), 64'h1);
    chk("rst_restart_to_sel", 64'(m_err_sel), 64'h4);
    drive('1, '1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
